// File: rtl/sd_ramdisk.sv
// sd_ramdisk: responder side of the byte-handshake SD sector interface, backed by an on-chip RAM.
// Define SD_RAMDISK_WR_LATENCY_EN to hold busy_o for WR_BUSY_CYCLES after a sector write.
module sd_ramdisk #(
    parameter int SECTORS        = 8,
    parameter int ADDR_W         = 3,
    parameter int WR_BUSY_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic              rd_i,
    input  logic              wr_i,
    output logic              busy_o,
    output logic              hndshk_o,
    input  logic              hndshk_i,
    output logic [7:0]        data_o,
    input  logic [7:0]        data_i,
    output logic              error_o
);
    localparam int IDX_W = $clog2(SECTORS * 512);
    localparam int AW1   = ADDR_W + 1;
    localparam int WB_W  = (WR_BUSY_CYCLES > 1) ? $clog2(WR_BUSY_CYCLES) : 1;
    localparam logic [WB_W-1:0] WB_LAST   = WB_W'(WR_BUSY_CYCLES - 1);
    localparam logic [AW1-1:0]  SECTORS_L = AW1'(SECTORS);
`ifdef SD_RAMDISK_WR_LATENCY_EN
    localparam bit WR_LAT_EN = 1'b1;
`else
    localparam bit WR_LAT_EN = 1'b0;
`endif

    typedef enum logic [3:0] {
        IDLE, RD_FETCH, RD_PRESENT, RD_ACK, RD_REL,
        WR_REQ, WR_ACK, WR_REL, WR_BUSY, DONE
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] sector;
    logic [8:0]        cnt;
    logic [WB_W-1:0]   wb_cnt;
    logic [7:0]        mem [SECTORS*512];
    logic [7:0]        ram_q;
    logic [IDX_W-1:0]  ram_idx;
    logic              ram_we;
    logic              addr_bad;

    // The top index bit is always zero when SECTORS is below 2**ADDR_W, because such sectors are rejected.
    assign ram_idx  = IDX_W'({sector, cnt});
    assign ram_we   = (state == WR_ACK) && hndshk_i;
    assign addr_bad = ({1'b0, addr_i} >= SECTORS_L);

    // The RAM has no reset, so its contents survive rst.
    always_ff @(posedge clk) begin
        if (ram_we)
            mem[ram_idx] <= data_i;
        ram_q <= mem[ram_idx];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            sector   <= '0;
            cnt      <= '0;
            wb_cnt   <= '0;
            busy_o   <= 1'b0;
            hndshk_o <= 1'b0;
            data_o   <= '0;
            error_o  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (wr_i || rd_i) begin
                        if (addr_bad) begin
                            error_o <= 1'b1;
                        end else begin
                            sector  <= addr_i;
                            cnt     <= '0;
                            busy_o  <= 1'b1;
                            error_o <= 1'b0;
                            state   <= wr_i ? WR_REQ : RD_FETCH;
                        end
                    end
                end
                RD_FETCH: state <= RD_PRESENT;
                RD_PRESENT: begin
                    data_o   <= ram_q;
                    hndshk_o <= 1'b1;
                    state    <= RD_ACK;
                end
                RD_ACK: begin
                    if (hndshk_i) begin
                        hndshk_o <= 1'b0;
                        state    <= RD_REL;
                    end
                end
                // Waiting for the host to release makes a long hndshk_i pulse count as one byte.
                RD_REL: begin
                    if (!hndshk_i) begin
                        if (cnt == 9'd511) begin
                            state <= DONE;
                        end else begin
                            cnt   <= cnt + 9'd1;
                            state <= RD_FETCH;
                        end
                    end
                end
                WR_REQ: begin
                    hndshk_o <= 1'b1;
                    state    <= WR_ACK;
                end
                WR_ACK: begin
                    if (hndshk_i) begin
                        hndshk_o <= 1'b0;
                        state    <= WR_REL;
                    end
                end
                WR_REL: begin
                    if (!hndshk_i) begin
                        if (cnt == 9'd511) begin
                            wb_cnt <= '0;
                            state  <= WR_BUSY;
                        end else begin
                            cnt   <= cnt + 9'd1;
                            state <= WR_REQ;
                        end
                    end
                end
                WR_BUSY: begin
                    if (!WR_LAT_EN || wb_cnt == WB_LAST)
                        state <= DONE;
                    else
                        wb_cnt <= wb_cnt + 1'b1;
                end
                DONE: begin
                    busy_o <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/sd_ramdisk.md
SD_RAMDISK -- requirements
Module: sd_ramdisk

Interface
REQ-001 SHALL have parameter SECTORS, default 8, number of 512-byte sectors held (power of two, >=2).
REQ-002 SHALL have parameter ADDR_W, default 3, sector address width (log2 SECTORS).
REQ-003 SHALL have parameter WR_BUSY_CYCLES, default 16, emulated post-write programming time in clk cycles (>=1).
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port addr_i  input  ADDR_W  sector address, sampled with the command.
REQ-007 SHALL have port rd_i  input  1  read-sector strobe, level-sampled in IDLE.
REQ-008 SHALL have port wr_i  input  1  write-sector strobe, level-sampled in IDLE.
REQ-009 SHALL have port busy_o  output  1  high for the whole sector transfer.
REQ-010 SHALL have port hndshk_o  output  1  responder handshake: byte valid (read) or byte request (write).
REQ-011 SHALL have port hndshk_i  input  1  host handshake: byte taken (read) or byte valid (write).
REQ-012 SHALL have port data_o  output  8  read byte to host.
REQ-013 SHALL have port data_i  input  8  write byte from host.
REQ-014 SHALL have port error_o  output  1  sticky out-of-range flag.

Function
REQ-015 SHALL implement the controller (responder) side of the byte-handshake SD sector interface, backed by an internal synchronous RAM of SECTORS*512 bytes; no SD card attached.
REQ-016 SHALL use states IDLE, RD_FETCH, RD_PRESENT, RD_ACK, RD_REL, WR_REQ, WR_ACK, WR_REL, WR_BUSY, DONE; 9-bit byte counter cnt; RAM index {sector, cnt}.
REQ-017 IDLE: wr_i=1 -> latch addr_i, cnt<=0, busy_o<=1, error_o<=0, go WR_REQ; else rd_i=1 -> same latching, go RD_FETCH; wr_i wins when both high.
REQ-018 Address addr_i >= SECTORS in IDLE with a strobe: error_o<=1, busy_o stays 0, state stays IDLE; with SECTORS==2**ADDR_W no address is out of range and error_o never sets.
REQ-019 Read: RD_FETCH issues RAM read; RD_PRESENT loads data_o, hndshk_o<=1; RD_ACK waits hndshk_i=1 then hndshk_o<=0; RD_REL waits hndshk_i=0 then cnt==511 -> DONE else cnt+1 -> RD_FETCH.
REQ-020 data_o SHALL hold its value from RD_PRESENT until the next RD_PRESENT.
REQ-021 Write: WR_REQ sets hndshk_o<=1; WR_ACK waits hndshk_i=1, writes data_i to RAM, hndshk_o<=0; WR_REL waits hndshk_i=0 then cnt==511 -> WR_BUSY else cnt+1 -> WR_REQ.
REQ-022 Each hndshk_i high phase SHALL transfer exactly one byte regardless of its length.
REQ-023 DONE: busy_o<=0, go IDLE; busy_o falls one cycle after final transfer completes (plus WR_BUSY for writes).
REQ-024 The host SHALL drop rd_i/wr_i once busy_o is high; a strobe still high on return to IDLE starts a new command.
REQ-025 cnt SHALL not wrap within a sector; exactly 512 handshakes per command.

Reset
REQ-026 rst SHALL immediately force state IDLE, busy_o=0, hndshk_o=0, data_o=0, error_o=0, cnt=0, including mid-transfer.
REQ-027 RAM contents SHALL be retained across rst; a write aborted by rst leaves bytes already accepted written, rest unchanged.

Configuration
REQ-028 Macro SD_RAMDISK_WR_LATENCY_EN defined: WR_BUSY holds busy_o=1 for exactly WR_BUSY_CYCLES cycles then goes DONE.
REQ-029 Macro SD_RAMDISK_WR_LATENCY_EN undefined: WR_BUSY is a single pass-through cycle to DONE; WR_BUSY_CYCLES ignored.

Verification
REQ-030 Write sector 3 with byte n = n[7:0]^8'h5A, then read sector 3 -> 512 read bytes match, busy_o low after each.
REQ-031 rd_i with addr_i=5, SECTORS=4, ADDR_W=3 -> error_o=1, busy_o stays 0; next valid rd_i clears error_o.
REQ-032 rd_i and wr_i high together, sector 1 -> write transfer (hndshk_o request first, no data_o update), readback matches.
REQ-033 rst after 100 read bytes -> busy_o=0, hndshk_o=0 same cycle; subsequent read of sector 3 still returns pattern.
REQ-034 Host holds hndshk_i high 10 cycles per byte -> exactly 512 bytes transferred, cnt advances once per handshake.
REQ-035 With SD_RAMDISK_WR_LATENCY_EN, WR_BUSY_CYCLES=16 -> busy_o falls 18 cycles after final hndshk_i fall (WR_REL, 16 WR_BUSY, DONE); without macro -> 3 cycles.
